// File: rtl/riscv_pq_multer_ctrl_if.sv
// EX-stage handshake between the pipeline and the PQ multiplier sequencer.
// The EX stage is the master; the sequencer is the slave.
interface riscv_pq_multer_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  enable_i;
    logic [6:0]            operator_i;
    logic [DATA_WIDTH-1:0] operand_a_i;
    logic [31:0]           operand_b_i;
    logic                  ready_o;
    logic                  result_valid_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  illegal_o;

    modport master (
        output enable_i, operator_i, operand_a_i, operand_b_i,
        input  ready_o, result_valid_o, result_o, illegal_o
    );

    modport slave (
        input  enable_i, operator_i, operand_a_i, operand_b_i,
        output ready_o, result_valid_o, result_o, illegal_o
    );
endinterface

// File: rtl/riscv_pq_multer_ctrl.sv
// Sequencer between EX and the polynomial-multiplier accelerator.
// Decodes MULTER_WRITE/CALC/READ, drives the coefficient memory and the
// start/done interface, stalls via ready_o and profiles calculation latency.
module riscv_pq_multer_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_pq_multer_ctrl_if.slave ex,
    output logic                  core_we_o,
    output logic                  core_re_o,
    output logic [ADDR_WIDTH-1:0] core_addr_o,
    output logic [DATA_WIDTH-1:0] core_wdata_o,
    input  logic [DATA_WIDTH-1:0] core_rdata_i,
    output logic                  core_start_o,
    input  logic                  core_done_i,
    output logic                  calc_busy_o,
    output logic [CNT_WIDTH-1:0]  calc_cycles_o
);

    localparam logic [6:0] OP_WRITE = 7'b0000000;
    localparam logic [6:0] OP_CALC  = 7'b0000001;
    localparam logic [6:0] OP_READ  = 7'b0000010;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t                state_q;
    logic                  core_we_q;
    logic                  core_re_q;
    logic                  core_start_q;
    logic [ADDR_WIDTH-1:0] core_addr_q;
    logic [DATA_WIDTH-1:0] core_wdata_q;
    logic                  result_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  illegal_q;
    logic                  calc_busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  is_mult_op;
    logic                  ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] idx;

    assign idx = ex.operand_b_i[ADDR_WIDTH-1:0];

    // Ready only in IDLE; multiplier ops additionally wait for the accelerator.
    always_comb begin
        is_mult_op = (ex.operator_i == OP_WRITE) ||
                     (ex.operator_i == OP_CALC)  ||
                     (ex.operator_i == OP_READ);
        ready      = (state_q == IDLE) && !(is_mult_op && calc_busy_q);
        accept     = ex.enable_i && ready;
    end

    // FSM, strobes, response and latency counter, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            core_we_q      <= 1'b0;
            core_re_q      <= 1'b0;
            core_start_q   <= 1'b0;
            core_addr_q    <= '0;
            core_wdata_q   <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            illegal_q      <= 1'b0;
            calc_busy_q    <= 1'b0;
            cnt_q          <= '0;
        end else begin
            core_we_q      <= 1'b0;
            core_re_q      <= 1'b0;
            core_start_q   <= 1'b0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;

            // The counter covers the start cycle through the done cycle and
            // saturates instead of wrapping.
            if (calc_busy_q) begin
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                if (core_done_i) begin
                    calc_busy_q <= 1'b0;
                end
            end

            // Strobes are set on acceptance so they appear in the state that names them.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (ex.operator_i)
                            OP_WRITE: begin
                                core_addr_q    <= idx;
                                core_wdata_q   <= ex.operand_a_i;
                                core_we_q      <= 1'b1;
                                result_valid_q <= 1'b1;
                                result_q       <= '0;
                                state_q        <= WR;
                            end
                            OP_READ: begin
                                core_addr_q <= idx;
                                core_re_q   <= 1'b1;
                                state_q     <= RD_REQ;
                            end
                            OP_CALC: begin
                                core_start_q   <= 1'b1;
                                calc_busy_q    <= 1'b1;
                                cnt_q          <= '0;
                                result_valid_q <= 1'b1;
                                result_q       <= '0;
                            end
                            default: begin
                                result_valid_q <= 1'b1;
                                result_q       <= '0;
                                illegal_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                WR:      state_q <= IDLE;
                RD_REQ:  state_q <= RD_WAIT;
                RD_WAIT: begin
                    result_q       <= core_rdata_i;
                    result_valid_q <= 1'b1;
                    state_q        <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex.ready_o        = ready;
    assign ex.result_valid_o = result_valid_q;
    assign ex.result_o       = result_q;
    assign ex.illegal_o      = illegal_q;
    assign core_we_o         = core_we_q;
    assign core_re_o         = core_re_q;
    assign core_addr_o       = core_addr_q;
    assign core_wdata_o      = core_wdata_q;
    assign core_start_o      = core_start_q;
    assign calc_busy_o       = calc_busy_q;
    assign calc_cycles_o     = cnt_q;

endmodule

// File: tb/tb_riscv_pq_multer_ctrl.sv
// Directed bench for riscv_pq_multer_ctrl: a default instance and a
// CNT_WIDTH=4 instance share stimulus and a small coefficient-memory model.
module tb_riscv_pq_multer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic [31:0] rdata;
    logic [31:0] mem [256];

    logic        we, re, start, busy;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [15:0] cycles;

    logic        we4, re4, start4, busy4;
    logic [7:0]  addr4;
    logic [31:0] wdata4;
    logic [3:0]  cycles4;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    riscv_pq_multer_ctrl_if #(.DATA_WIDTH(32)) ex ();
    riscv_pq_multer_ctrl_if #(.DATA_WIDTH(32)) ex4 ();

    assign ex4.enable_i    = ex.enable_i;
    assign ex4.operator_i  = ex.operator_i;
    assign ex4.operand_a_i = ex.operand_a_i;
    assign ex4.operand_b_i = ex.operand_b_i;

    riscv_pq_multer_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ex(ex),
        .core_we_o(we), .core_re_o(re), .core_addr_o(addr), .core_wdata_o(wdata),
        .core_rdata_i(rdata), .core_start_o(start), .core_done_i(done),
        .calc_busy_o(busy), .calc_cycles_o(cycles)
    );

    riscv_pq_multer_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ex(ex4),
        .core_we_o(we4), .core_re_o(re4), .core_addr_o(addr4), .core_wdata_o(wdata4),
        .core_rdata_i(rdata), .core_start_o(start4), .core_done_i(done),
        .calc_busy_o(busy4), .calc_cycles_o(cycles4)
    );

    always #5 clk = ~clk;

    // Coefficient memory: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        ex.enable_i    = en;
        ex.operator_i  = op;
        ex.operand_a_i = a;
        ex.operand_b_i = b;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ex.ready_o, 1'b1);
        check({tag, "_rv"}, ex.result_valid_o, 1'b0);
        check({tag, "_res"}, ex.result_o, 32'h0);
        check({tag, "_ill"}, ex.illegal_o, 1'b0);
        check({tag, "_we"}, we, 1'b0);
        check({tag, "_re"}, re, 1'b0);
        check({tag, "_addr"}, addr, 8'h00);
        check({tag, "_wdata"}, wdata, 32'h0);
        check({tag, "_start"}, start, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cyc"}, cycles, 16'h0);
    endtask

    task automatic write_test(input string tag);
        drive(1'b1, 7'b0000000, 32'hDEADBEEF, 32'h105);
        check({tag, "_acc_ready"}, ex.ready_o, 1'b1);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        check({tag, "_we"}, we, 1'b1);
        check({tag, "_addr"}, addr, 8'h05);
        check({tag, "_wdata"}, wdata, 32'hDEADBEEF);
        check({tag, "_rv"}, ex.result_valid_o, 1'b1);
        check({tag, "_res"}, ex.result_o, 32'h0);
        check({tag, "_ready_t1"}, ex.ready_o, 1'b0);
        step();
        check({tag, "_we_t2"}, we, 1'b0);
        check({tag, "_rv_t2"}, ex.result_valid_o, 1'b0);
        check({tag, "_ready_t2"}, ex.ready_o, 1'b1);
        check({tag, "_addr_hold"}, addr, 8'h05);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rdata = 32'h0;
        done  = 1'b0;
        rst   = 1'b1;
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("rst");

        // WRITE a=0xDEADBEEF to index 5 (upper index bits ignored)
        write_test("wr");

        // READ index 5
        drive(1'b1, 7'b0000010, 32'h0, 32'h05);
        check("rd_acc_ready", ex.ready_o, 1'b1);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        check("rd_re_t1", re, 1'b1);
        check("rd_addr_t1", addr, 8'h05);
        check("rd_rv_t1", ex.result_valid_o, 1'b0);
        step();
        check("rd_re_t2", re, 1'b0);
        check("rd_rv_t2", ex.result_valid_o, 1'b0);
        step();
        check("rd_rv_t3", ex.result_valid_o, 1'b1);
        check("rd_res_t3", ex.result_o, 32'hDEADBEEF);
        check("rd_ready_t3", ex.ready_o, 1'b0);
        step();
        check("rd_rv_t4", ex.result_valid_o, 1'b0);
        check("rd_ready_t4", ex.ready_o, 1'b1);

        // CALC, done 20 cycles after acceptance, READ stalled throughout
        drive(1'b1, 7'b0000001, 32'h0, 32'h0);
        check("calc_acc_ready", ex.ready_o, 1'b1);
        step();
        drive(1'b1, 7'b0000010, 32'h0, 32'h05);
        check("calc_start", start, 1'b1);
        check("calc_rv", ex.result_valid_o, 1'b1);
        check("calc_res", ex.result_o, 32'h0);
        check("calc_cyc_t1", cycles, 16'd0);
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("calc_busy_%0d", i), busy, 1'b1);
            check($sformatf("calc_stall_%0d", i), ex.ready_o, 1'b0);
            if (i > 1) check($sformatf("calc_nostart_%0d", i), start, 1'b0);
            if (i == 10) check("calc_cyc_mid", cycles, 16'd9);
            if (i == 20) done = 1'b1;
            step();
        end
        done = 1'b0;
        #1;
        check("calc_busy_end", busy, 1'b0);
        check("calc_cycles", cycles, 16'd20);
        check("calc_cycles4", cycles4, 4'd15);
        check("calc_rd_accept", ex.ready_o, 1'b1);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        check("calc_rd_re", re, 1'b1);
        step();
        step();
        check("calc_rd_rv", ex.result_valid_o, 1'b1);
        check("calc_rd_res", ex.result_o, 32'hDEADBEEF);
        check("calc_cycles_hold", cycles, 16'd20);
        step();

        // 40-cycle CALC with an illegal operator accepted while busy
        drive(1'b1, 7'b0000001, 32'h0, 32'h0);
        step();
        drive(1'b1, 7'b0000111, 32'h0, 32'h0);
        check("ill_ready", ex.ready_o, 1'b1);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        check("ill_rv", ex.result_valid_o, 1'b1);
        check("ill_res", ex.result_o, 32'h0);
        check("ill_flag", ex.illegal_o, 1'b1);
        check("ill_busy", busy, 1'b1);
        step();
        check("ill_flag_clr", ex.illegal_o, 1'b0);
        for (int i = 3; i < 40; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        #1;
        check("sat_busy", busy, 1'b0);
        check("sat_cycles16", cycles, 16'd40);
        check("sat_cycles4", cycles4, 4'd15);

        // Spurious done while idle
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check("spur_busy", busy, 1'b0);
        check("spur_start", start, 1'b0);
        check("spur_cycles16", cycles, 16'd40);
        check("spur_cycles4", cycles4, 4'd15);
        check("spur_rv", ex.result_valid_o, 1'b0);

        // Reset during RD_WAIT
        drive(1'b1, 7'b0000010, 32'h0, 32'h05);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_rd");
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst_rd_norv_%0d", i), ex.result_valid_o, 1'b0);
        end

        // Reset during calc_busy
        drive(1'b1, 7'b0000001, 32'h0, 32'h0);
        step();
        drive(1'b0, 7'b0000000, 32'h0, 32'h0);
        step();
        check("rst_calc_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_calc");
        step();
        check("rst_calc_norv", ex.result_valid_o, 1'b0);
        check("rst_calc_nobusy", busy, 1'b0);

        write_test("wr2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_pq_multer_ctrl.md
# riscv_pq_multer_ctrl

Sequencer between the EX stage and the polynomial-multiplier accelerator for the post-quantum custom opcode. It decodes the three multiplier PQ operations (MULTER_WRITE, MULTER_CALC, MULTER_READ), drives the accelerator's coefficient-memory and start/done interface, and stalls the pipeline through a ready handshake while the accelerator is busy. It also measures the latency of the last calculation for performance profiling.

## Interface
Parameters:
- ADDR_WIDTH, 8: coefficient index width (256 coefficients).
- DATA_WIDTH, 32: coefficient and result width.
- CNT_WIDTH, 16: width of the calculation-latency counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  PQ multiplier instruction present in EX.
- operator_i  in  7  PQ operator: WRITE=7'b0000000, CALC=7'b0000001, READ=7'b0000010.
- operand_a_i  in  DATA_WIDTH  write data.
- operand_b_i  in  32  coefficient index in bits [ADDR_WIDTH-1:0]; upper bits are ignored.
- ready_o  out  1  instruction accepted this cycle when enable_i && ready_o.
- result_valid_o  out  1  one-cycle pulse carrying result_o.
- result_o  out  DATA_WIDTH  read data; 0 for WRITE, CALC and illegal operators.
- illegal_o  out  1  one-cycle pulse when an unknown operator is accepted.
- core_we_o  out  1  coefficient write strobe.
- core_re_o  out  1  coefficient read strobe.
- core_addr_o  out  ADDR_WIDTH  coefficient index.
- core_wdata_o  out  DATA_WIDTH  write data.
- core_rdata_i  in  DATA_WIDTH  read data, valid in the cycle after core_re_o.
- core_start_o  out  1  one-cycle start pulse.
- core_done_i  in  1  one-cycle completion pulse from the accelerator.
- calc_busy_o  out  1  a calculation is in flight.
- calc_cycles_o  out  CNT_WIDTH  latency of the last or current calculation.

## Operation
- States are IDLE, WR, RD_REQ, RD_WAIT and RESP. The calc_busy flag is independent of the FSM state.
- Combinational ready rule:
  - ready_o = 1 only in IDLE.
  - If the operator is WRITE, CALC or READ, ready_o additionally requires calc_busy = 0.
  - Illegal operators are never blocked by calc_busy.
- Accepting WRITE: IDLE→WR. Register operand_a_i and the index.
- Accepting READ: IDLE→RD_REQ. Register the index.
- Accepting CALC:
  - Stay in IDLE.
  - Next cycle: core_start_o=1, calc_busy←1, calc_cycles←0, result_valid_o=1, result_o=0.
  - CALC is non-blocking for the pipeline.
- Accepting an illegal operator: stay in IDLE. Next cycle: result_valid_o=1, result_o=0, illegal_o=1.
- WR state:
  - core_we_o=1 with the registered addr/wdata.
  - result_valid_o=1, result_o=0.
  - Then →IDLE.
- RD_REQ: core_re_o=1, then →RD_WAIT.
- RD_WAIT: capture core_rdata_i into the result register, then →RESP.
- RESP: result_valid_o=1 with the captured data, then →IDLE.
- Latency counter:
  - Increments every cycle calc_busy=1, starting with the start-pulse cycle.
  - Saturates at 2^CNT_WIDTH−1; no wrap.
  - Holds its value after done until the next CALC start.
- core_done_i while calc_busy=1: calc_busy←0 in the next cycle. The counter includes the done cycle.
- core_done_i while calc_busy=0: ignored. No state change.
- core_addr_o and core_wdata_o hold their last values when no strobe is active.
- Reset mid-operation:
  - FSM→IDLE; calc_busy←0; counter←0.
  - No pending response or strobe is emitted after reset.
  - The accelerator shares rst and is reset alongside.

## Timing
- Reset values: ready_o=1 (IDLE, not busy); every other output 0, including core_addr_o, core_wdata_o and calc_cycles_o.
- All core_* outputs, result_o, result_valid_o and illegal_o are registered. ready_o is the only combinational output.
- WRITE: accept at T; core_we_o and result_valid_o at T+1; ready_o=1 at T+2.
- READ: accept at T; core_re_o at T+1; rdata sampled at T+2; result_valid_o at T+3; ready_o=1 at T+4.
- CALC: accept at T; start pulse and result at T+1; calc_busy_o=1 from T+1.
- Calculation end: with core_done_i at D, calc_busy_o=0 at D+1 and calc_cycles_o = D−T.
  - A stalled WRITE/READ/CALC is accepted at D+1 at the earliest.
- core_done_i coincident with a new multiplier request: that request stalls that cycle and is accepted in the next cycle.
- At most one operation is in the FSM at a time. Back-to-back WRITEs issue one per 2 cycles.

## Test plan
- Reset then WRITE of a=0xDEADBEEF, b=0x105: core_we_o at T+1 with addr=0x05 and wdata=0xDEADBEEF; result_valid_o at T+1 with result_o=0; ready_o high at T+2.
- READ of b=0x05 with the model returning 0xDEADBEEF: core_re_o at T+1; result_valid_o at T+3 with result_o=0xDEADBEEF; no other result pulses.
- CALC with done 20 cycles after start:
  - core_start_o is a single pulse; calc_busy_o is high for 20 cycles.
  - A READ presented throughout is held with ready_o=0 and accepted the cycle after busy falls.
  - calc_cycles_o=20.
- Illegal operator 7'b0000111 during calc_busy: accepted immediately; result_valid_o=1, result_o=0, illegal_o=1; calc_busy_o is unaffected.
- Forced CNT_WIDTH=4 with a 40-cycle calculation: calc_cycles_o saturates at 15. A spurious core_done_i while idle causes no change.
- rst asserted during RD_WAIT and again during calc_busy: all outputs return to reset values next cycle; no result_valid_o is emitted afterwards; the next WRITE behaves as in the first test.
